// File: rtl/xbus_psum_gather.sv
// ---------------------------------------------------------------------------
// xbus_psum_gather
//
// Row-bus partial-sum return controller. Collects psums from the NUM_COL PEs
// on one row bus, picks one per cycle with a round-robin arbiter, queues them
// in a small return FIFO and presents them to the global buffer tagged with
// the source column and the row tag that was committed when the psum was
// accepted. The bus only accepts psums while the committed row tag matches
// y_id. A flush drains the FIFO before the new tag is committed.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   flush          single-cycle request to drain and retag
//   y_tag_in       new row tag, sampled with flush
//   y_id           this bus's row ID (static after reset)
//   pe_psum_valid  per-column psum valid
//   pe_psum_data   per-column psums, column c at [c*2*DATA_WIDTH +: 2*DATA_WIDTH]
//   pe_psum_ready  one-hot (or zero) grant back to the PEs
//   gb_psum_valid  FIFO head valid toward the global buffer
//   gb_psum_data   head psum
//   gb_psum_x_id   source column of the head psum
//   gb_psum_y_id   row tag committed when the head psum was accepted
//   gb_psum_ready  global-buffer accept
//   busy           high while draining
//   stall_cnt      arbitration stall counter (optional)
//
// Optional feature: define XBUS_PSUM_STALL_CNT_EN to build the saturating
// stall counter; otherwise stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
module xbus_psum_gather #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int NUM_ROW    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [$clog2(NUM_ROW)-1:0]        y_tag_in,
    input  logic [$clog2(NUM_ROW)-1:0]        y_id,
    input  logic [NUM_COL-1:0]                pe_psum_valid,
    input  logic [NUM_COL*2*DATA_WIDTH-1:0]   pe_psum_data,
    output logic [NUM_COL-1:0]                pe_psum_ready,
    output logic                              gb_psum_valid,
    output logic [2*DATA_WIDTH-1:0]           gb_psum_data,
    output logic [$clog2(NUM_COL)-1:0]        gb_psum_x_id,
    output logic [$clog2(NUM_ROW)-1:0]        gb_psum_y_id,
    input  logic                              gb_psum_ready,
    output logic                              busy,
    output logic [15:0]                       stall_cnt
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int XW = $clog2(NUM_COL);
    localparam int YW = $clog2(NUM_ROW);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [XW-1:0] LAST_COL_C = XW'(NUM_COL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [YW-1:0]   tag_r;
    logic [YW-1:0]   tag_s;
    logic [YW-1:0]   pend_r;
    logic [YW-1:0]   pend_s;
    logic            busy_r;

    logic [XW-1:0]   last_grant_r;
    logic [XW-1:0]   cand_s;
    logic [XW-1:0]   grant_idx_s;
    logic            grant_found_s;
    logic            arb_en_s;
    logic            push_s;
    logic            pop_s;
    logic            drain_done_s;
    logic [PW-1:0]   push_data_s;

    logic [PW-1:0]   data_mem_r [FIFO_DEPTH];
    logic [XW-1:0]   x_mem_r    [FIFO_DEPTH];
    logic [YW-1:0]   y_mem_r    [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    // Head of the FIFO is always presented; valid follows the registered count.
    assign gb_psum_valid = (count_r != {CW{1'b0}});
    assign gb_psum_data  = data_mem_r[rd_ptr_r];
    assign gb_psum_x_id  = x_mem_r[rd_ptr_r];
    assign gb_psum_y_id  = y_mem_r[rd_ptr_r];
    assign busy          = busy_r;

    assign pop_s    = gb_psum_valid & gb_psum_ready;
    // Full-with-pop must not raise ready, so only the registered count matters.
    assign arb_en_s = (state_r == ST_ACTIVE) && (count_r < DEPTH_C);
    assign push_s   = arb_en_s & grant_found_s;
    assign push_data_s = pe_psum_data[int'(grant_idx_s) * PW +: PW];

    // The drain completes on the cycle the last entry leaves as well as when empty.
    assign drain_done_s = (count_r == {CW{1'b0}}) ||
                          ((count_r == CW'(1)) && pop_s);

    // Next-state and tag commit logic; flush always wins and reloads pending_tag.
    always_comb begin
        state_s = state_r;
        tag_s   = tag_r;
        pend_s  = pend_r;
        if (flush) begin
            state_s = ST_DRAIN;
            pend_s  = y_tag_in;
        end else if ((state_r == ST_DRAIN) && drain_done_s) begin
            tag_s   = pend_r;
            state_s = (pend_r == y_id) ? ST_ACTIVE : ST_IDLE;
        end else begin
            state_s = state_r;
        end
    end

    // State, tag and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            tag_r   <= {YW{1'b0}};
            pend_r  <= {YW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tag_r   <= tag_s;
            pend_r  <= pend_s;
            busy_r  <= (state_s == ST_DRAIN);
        end
    end

    // Round-robin search: first valid column strictly after last_grant, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {XW{1'b0}};
        cand_s        = {XW{1'b0}};
        pe_psum_ready = {NUM_COL{1'b0}};
        for (int k = 1; k <= NUM_COL; k++) begin
            cand_s = XW'((int'(last_grant_r) + k) % NUM_COL);
            if (!grant_found_s && pe_psum_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        if (arb_en_s && grant_found_s) begin
            pe_psum_ready[grant_idx_s] = 1'b1;
        end else begin
            pe_psum_ready = {NUM_COL{1'b0}};
        end
    end

    // FIFO pointers, occupancy and arbiter history.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            last_grant_r <= LAST_COL_C;
        end else begin
            if (push_s) begin
                wr_ptr_r     <= wr_ptr_r + AW'(1);
                last_grant_r <= grant_idx_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= {PW{1'b0}};
                x_mem_r[i]    <= {XW{1'b0}};
                y_mem_r[i]    <= {YW{1'b0}};
            end
        end else if (push_s) begin
            data_mem_r[wr_ptr_r] <= push_data_s;
            x_mem_r[wr_ptr_r]    <= grant_idx_s;
            y_mem_r[wr_ptr_r]    <= tag_r;
        end
    end

`ifdef XBUS_PSUM_STALL_CNT_EN
    logic [15:0] stall_cnt_r;
    logic        stall_s;

    // A stall cycle: ACTIVE and some requesting column was not granted.
    assign stall_s = (state_r == ST_ACTIVE) &&
                     ((pe_psum_valid & ~pe_psum_ready) != {NUM_COL{1'b0}});

    // Saturating stall counter, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_xbus_psum_gather.sv
// ---------------------------------------------------------------------------
// tb_xbus_psum_gather
//
// Directed bench for xbus_psum_gather (default parameters). A reference model
// predicts the grant and the FIFO contents; expected psums are queued when a
// PE transfer is predicted and compared against the global-buffer side when
// they reach the head. Directed steps add constant checks for the key cases.
// ---------------------------------------------------------------------------
module tb_xbus_psum_gather;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  y_tag_in;
    logic [1:0]  y_id;
    logic [3:0]  pe_psum_valid;
    logic [127:0] pe_psum_data;
    logic [3:0]  pe_psum_ready;
    logic        gb_psum_valid;
    logic [31:0] gb_psum_data;
    logic [1:0]  gb_psum_x_id;
    logic [1:0]  gb_psum_y_id;
    logic        gb_psum_ready;
    logic        busy;
    logic [15:0] stall_cnt;

    xbus_psum_gather dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .y_tag_in      (y_tag_in),
        .y_id          (y_id),
        .pe_psum_valid (pe_psum_valid),
        .pe_psum_data  (pe_psum_data),
        .pe_psum_ready (pe_psum_ready),
        .gb_psum_valid (gb_psum_valid),
        .gb_psum_data  (gb_psum_data),
        .gb_psum_x_id  (gb_psum_x_id),
        .gb_psum_y_id  (gb_psum_y_id),
        .gb_psum_ready (gb_psum_ready),
        .busy          (busy),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0 = IDLE, 1 = ACTIVE, 2 = DRAIN.
    int          ref_state;
    logic [1:0]  ref_tag;
    logic [1:0]  ref_pend;
    int          ref_last;
    logic [15:0] ref_stall;
    logic [35:0] q [$];     // {data[31:0], x[1:0], y[1:0]}

    // Values captured at the falling edge of the most recent cycle.
    logic [3:0]  obs_ready;
    logic        obs_gbv;
    logic [1:0]  obs_gbx;
    logic [31:0] obs_data;
    logic [1:0]  obs_y;
    logic        obs_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        flush         = 1'b0;
        y_tag_in      = 2'd0;
        pe_psum_valid = 4'b0000;
        gb_psum_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b0;
        q.delete();
        ref_state = 0;
        ref_tag   = 2'd0;
        ref_pend  = 2'd0;
        ref_last  = 3;
        ref_stall = 16'h0000;
    endtask

    // One clock: compare at the falling edge, advance the model, step past the rising edge.
    task automatic cycle();
        logic [3:0]  er;
        logic [35:0] ent;
        int          eidx;
        int          c;
        er   = 4'b0000;
        eidx = 0;
        @(negedge clk);
        if (ref_state == 1 && q.size() < 4) begin
            for (int k = 1; k <= 4; k++) begin
                c = (ref_last + k) % 4;
                if (er == 4'b0000 && pe_psum_valid[c]) begin
                    er[c] = 1'b1;
                    eidx  = c;
                end
            end
        end
        obs_ready = pe_psum_ready;
        obs_gbv   = gb_psum_valid;
        obs_gbx   = gb_psum_x_id;
        obs_data  = gb_psum_data;
        obs_y     = gb_psum_y_id;
        obs_busy  = busy;
        check("pe_psum_ready", 64'(pe_psum_ready), 64'(er));
        check("gb_psum_valid", 64'(gb_psum_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            ent = q[0];
            check("gb_psum_data", 64'(gb_psum_data), 64'(ent[35:4]));
            check("gb_psum_x_id", 64'(gb_psum_x_id), 64'(ent[3:2]));
            check("gb_psum_y_id", 64'(gb_psum_y_id), 64'(ent[1:0]));
        end
        check("busy", 64'(busy), 64'(ref_state == 2));
        check("stall_cnt", 64'(stall_cnt), 64'(ref_stall));

        if (q.size() != 0 && gb_psum_ready) void'(q.pop_front());
        if (er != 4'b0000) begin
            q.push_back({pe_psum_data[eidx*32 +: 32], eidx[1:0], ref_tag});
            ref_last = eidx;
        end
`ifdef XBUS_PSUM_STALL_CNT_EN
        if (flush) ref_stall = 16'h0000;
        else if (ref_state == 1 && (pe_psum_valid & ~er) != 4'b0000 && ref_stall != 16'hFFFF)
            ref_stall = ref_stall + 16'h0001;
`endif
        if (flush) begin
            ref_state = 2;
            ref_pend  = y_tag_in;
        end else if (ref_state == 2 && q.size() == 0) begin
            ref_tag   = ref_pend;
            ref_state = (ref_pend == y_id) ? 1 : 0;
        end
        @(posedge clk); #1;
    endtask

    logic [3:0]  exp_rr_ready [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0]  exp_rr_x     [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [15:0] exp_stall8;
    int          n_push;
    int          n_pop;
    logic [3:0]  acc_ready;
    logic        acc_gbv;

    initial begin
`ifdef XBUS_PSUM_STALL_CNT_EN
        exp_stall8 = 16'd8;
`else
        exp_stall8 = 16'd0;
`endif
        pe_psum_data = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
        y_id = 2'd2;
        do_reset();

        // Reset state.
        check("rst_ready", 64'(pe_psum_ready), 64'h0);
        check("rst_gbv",   64'(gb_psum_valid), 64'h0);
        check("rst_data",  64'(gb_psum_data),  64'h0);
        check("rst_x",     64'(gb_psum_x_id),  64'h0);
        check("rst_y",     64'(gb_psum_y_id),  64'h0);
        check("rst_busy",  64'(busy),          64'h0);
        check("rst_stall", 64'(stall_cnt),     64'h0);

        // Basic return: retag to 2, PE1 offers one psum.
        flush = 1'b1; y_tag_in = 2'd2;
        cycle();
        flush = 1'b0;
        cycle();
        check("basic_busy_hi", 64'(obs_busy), 64'h1);
        pe_psum_data[32 +: 32] = 32'h0000_1234;
        pe_psum_valid = 4'b0010;
        cycle();
        check("basic_busy_lo", 64'(obs_busy), 64'h0);
        check("basic_grant", 64'(obs_ready), 64'h2);
        pe_psum_valid = 4'b0000;
        cycle();
        check("basic_gbv",  64'(obs_gbv),  64'h1);
        check("basic_data", 64'(obs_data), 64'h0000_1234);
        check("basic_x",    64'(obs_gbx),  64'h1);
        check("basic_y",    64'(obs_y),    64'h2);
        gb_psum_ready = 1'b1;
        cycle();
        cycle();
        pe_psum_data[32 +: 32] = 32'hB1B1_0001;

        // Tag mismatch, with a second flush during DRAIN overwriting the tag.
        do_reset();
        y_id = 2'd1;
        flush = 1'b1; y_tag_in = 2'd1;
        cycle();
        y_tag_in = 2'd3;
        cycle();
        flush = 1'b0;
        pe_psum_valid = 4'b1111;
        acc_ready = 4'b0000; acc_gbv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            acc_ready = acc_ready | obs_ready;
            acc_gbv   = acc_gbv | obs_gbv;
        end
        check("mismatch_ready", 64'(acc_ready), 64'h0);
        check("mismatch_gbv",   64'(acc_gbv),   64'h0);

        // Round-robin with sustained one-per-cycle return.
        do_reset();
        y_id = 2'd2;
        flush = 1'b1; y_tag_in = 2'd2;
        cycle();
        flush = 1'b0;
        cycle();
        pe_psum_valid = 4'b1111; gb_psum_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (i < 6) check("rr_grant", 64'(obs_ready), 64'(exp_rr_ready[i]));
            if (i > 0) begin
                check("rr_gbv", 64'(obs_gbv), 64'h1);
                check("rr_x",   64'(obs_gbx), 64'(exp_rr_x[i-1]));
            end
        end
        pe_psum_valid = 4'b0000;
        cycle();
        cycle();

        // Backpressure: exactly four pushes, then resume one cycle after a pop.
        gb_psum_ready = 1'b0; pe_psum_valid = 4'b1111;
        n_push = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (obs_ready != 4'b0000) n_push++;
        end
        check("full_pushes", 64'(n_push), 64'd4);
        check("full_ready0", 64'(obs_ready), 64'h0);
        gb_psum_ready = 1'b1;
        cycle();
        check("full_pop_noready", 64'(obs_ready), 64'h0);
        check("full_head_x",      64'(obs_gbx),   64'h3);
        cycle();
        check("full_resume", 64'(obs_ready), 64'h8);
        pe_psum_valid = 4'b0000;
        for (int i = 0; i < 4; i++) cycle();

        // Flush mid-stream: three queued, retag to 0 while y_id is 2.
        gb_psum_ready = 1'b0; pe_psum_valid = 4'b1111;
        for (int i = 0; i < 3; i++) cycle();
        pe_psum_valid = 4'b0000; flush = 1'b1; y_tag_in = 2'd0; gb_psum_ready = 1'b1;
        n_pop = 0;
        cycle();
        if (obs_gbv && gb_psum_ready) n_pop++;
        flush = 1'b0; pe_psum_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (obs_gbv && gb_psum_ready) n_pop++;
        end
        check("flush_pops",  64'(n_pop),     64'd3);
        check("flush_busy",  64'(obs_busy),  64'h0);
        check("flush_ready", 64'(obs_ready), 64'h0);

        // Stall counter over eight ACTIVE cycles with all columns requesting.
        do_reset();
        y_id = 2'd2;
        flush = 1'b1; y_tag_in = 2'd2;
        cycle();
        flush = 1'b0;
        cycle();
        pe_psum_valid = 4'b1111; gb_psum_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check("stall_8", 64'(stall_cnt), 64'(exp_stall8));
        pe_psum_valid = 4'b0000;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
